d_cache_arbiter: RTL
====================

// Module: d_cache_arbiter
// PURPOSE
//  Single owner of the d_cache port (addr/wd/we/rd). Shares it between the MEM-stage core port and a host/loader port.
//  Core always has priority; the host gets a bounded-wait slot so it cannot starve.
//  After reset, a CLEAR sequence zeroes the whole d_cache before any requester is served.
//  Bad (out-of-range) accesses are blocked here and flagged.
//  Sits between the pipeline MEM stage / testbench loader and d_cache.
// PARAMETERS
//  Depth    120  d_cache size in bytes; must match d_cache Depth and be a multiple of 4
//  MaxWait  4    cycles a host request may wait before a forced host slot (>=1)
//  DoClear  1    1: run CLEAR after reset; 0: go straight to RUN
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous active-high reset
//  core_req     in   1    MEM stage access this cycle (memwriteM or load)
//  core_we      in   1    1=store, 0=load
//  core_addr    in   DPW  byte address (aluresultM)
//  core_wd      in   DPW  store data (Rd2M)
//  core_rdata   out  DPW  load data, valid the cycle after the grant
//  core_stall   out  1    core request not granted this cycle; hold the request
//  core_err     out  1    1-cycle pulse: granted core access was out of range
//  host_valid   in   1    host request; held with stable fields until host_ready
//  host_ready   out  1    host request granted this cycle (handshake completes)
//  host_we      in   1    1=write, 0=read
//  host_addr    in   DPW  byte address
//  host_wdata   in   DPW  write data
//  host_rdata   out  DPW  read data, qualified by host_rvalid
//  host_rvalid  out  1    1-cycle pulse, cycle after a granted host read
//  host_err     out  1    1-cycle pulse: granted host access was out of range
//  mem_addr     out  DPW  to d_cache addr
//  mem_wd       out  DPW  to d_cache wd
//  mem_we       out  1    to d_cache we
//  mem_rd       in   DPW  from d_cache rd (registered in d_cache, 1-cycle latency)
//  init_done    out  1    high once CLEAR has finished; stays high until rst
// BEHAVIOUR
//  Reset values (async, rst=1): state=CLEAR (RUN if DoClear=0), clear_ptr=0, wait_cnt=0.
//   All outputs 0 except core_stall=1 when DoClear=1.
//  CLEAR:
//   - Each cycle: mem_we=1, mem_addr=clear_ptr, mem_wd=0; clear_ptr+=4.
//   - After the write at Depth-4: init_done<=1 and state<=RUN. CLEAR takes Depth/4 cycles.
//   - During CLEAR: core_stall=1 and host_ready=0.
//   - rst asserted mid-CLEAR restarts CLEAR from address 0.
//  RUN arbitration, one grant per cycle:
//   - Host is granted when host_valid=1 and either core_req=0, or wait_cnt==MaxWait (forced).
//   - Otherwise the core is granted if core_req=1.
//   - core_stall = core_req & ~core_grant. In RUN it is high only in a forced host slot.
//  wait_cnt:
//   - Increments each cycle host_valid=1 and the host is not granted.
//   - Clears on a host grant or when host_valid=0.
//   - Saturates at MaxWait.
//  Grant mux:
//   - mem_addr/mem_wd/mem_we come from the granted requester.
//   - With no grant: mem_we=0 and mem_addr holds its last value.
//  Range check:
//   - An access is illegal when addr > Depth-4. Computed in 33 bits, so no wrap at 0xFFFF_FFFD.
//   - Illegal write: mem_we forced 0.
//   - Illegal read: the next-cycle rdata is forced to 0.
//   - Either case: the requester's err output pulses in the grant cycle.
//   - host_ready still asserts for an illegal host access (handshake completes).
//  Read return:
//   - A core read granted in cycle N: core_rdata = mem_rd in cycle N+1.
//   - A host read granted in cycle N: host_rvalid=1 and host_rdata=mem_rd in cycle N+1.
//   - A read flag register tracks which requester owns the returning data.
//   - core_rdata holds its last value when no core read returns.
//  Writes complete in the grant cycle; d_cache updates at that edge.
//  Same-cycle core write + host read to the same address (host granted): host sees the old data; core is stalled and writes next cycle.
// TESTING
//  1. rst pulse, Depth=120 -> CLEAR runs 30 cycles with mem_addr 0,4,...,116 and mem_wd=0; init_done rises on cycle 31; core_stall is 1 throughout CLEAR.
//  2. Core store 0xDEADBEEF @8, then load @8 -> core_rdata=0xDEADBEEF one cycle after the load grant; no stall.
//  3. core_req=1 every cycle, host_valid=1 from cycle 0 (MaxWait=4) -> host_ready only in cycle 4; core_stall=1 only in cycle 4; core access retried in cycle 5.
//  4. Host write 0x12345678 @116 succeeds; host write @117 -> host_err pulse, mem_we=0, memory unchanged; core load @0xFFFF_FFFE -> core_err, core_rdata=0.
//  5. rst asserted when clear_ptr=40 -> outputs reset immediately; CLEAR restarts at 0; init_done=0 until the full 30-cycle sweep completes.
//  6. Host read @8 with core idle -> host_ready at grant, host_rvalid=1 with host_rdata=0xDEADBEEF one cycle later.

Source files
------------

// File: rtl/d_cache_arbiter.sv
// d_cache_arbiter: clears the d_cache after reset, then shares its port between the core (priority) and a host port that is guaranteed a slot within MaxWait cycles
module d_cache_arbiter #(
  parameter int Depth   = 120,
  parameter int MaxWait = 4,
  parameter int DoClear = 1,
  parameter int DPW     = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           core_req_i,
  input  logic           core_we_i,
  input  logic [DPW-1:0] core_addr_i,
  input  logic [DPW-1:0] core_wd_i,
  output logic [DPW-1:0] core_rdata_o,
  output logic           core_stall_o,
  output logic           core_err_o,
  input  logic           host_valid_i,
  output logic           host_ready_o,
  input  logic           host_we_i,
  input  logic [DPW-1:0] host_addr_i,
  input  logic [DPW-1:0] host_wdata_i,
  output logic [DPW-1:0] host_rdata_o,
  output logic           host_rvalid_o,
  output logic           host_err_o,
  output logic [DPW-1:0] mem_addr_o,
  output logic [DPW-1:0] mem_wd_o,
  output logic           mem_we_o,
  input  logic [DPW-1:0] mem_rd_i,
  output logic           init_done_o
);
  localparam int WW = $clog2(MaxWait + 1);
  localparam logic [DPW:0] LastAddr = (DPW+1)'(Depth - 4);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [DPW-1:0] clear_ptr_q, mem_addr_q, core_rdata_q;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic init_done_q, core_rd_q, host_rd_q, rd_bad_q;
  logic run, forced, host_grant, core_grant, core_bad, host_bad;
  // out-of-range checks are done one bit wider so addresses near 2^DPW cannot wrap into range
  assign core_bad   = {1'b0, core_addr_i} > LastAddr;
  assign host_bad   = {1'b0, host_addr_i} > LastAddr;
  assign run        = state_q == RUN;
  assign forced     = wait_cnt_q == WW'(MaxWait);
  assign host_grant = run & host_valid_i & (~core_req_i | forced);
  assign core_grant = run & core_req_i & ~host_grant;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= (DoClear != 0) ? CLEAR : RUN;
    else state_q <= state_d;
  // next state: leave CLEAR after the last word is written; host wait age saturates at MaxWait
  always_comb begin
    state_d    = (state_q == CLEAR && clear_ptr_q == DPW'(Depth - 4)) ? RUN : state_q;
    wait_cnt_d = (host_grant | ~host_valid_i) ? '0 : forced ? wait_cnt_q : wait_cnt_q + 1'b1;
  end
  // clear sweep, wait age, held address/data and read-return ownership
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clear_ptr_q  <= '0;
      init_done_q  <= 1'b0;
      wait_cnt_q   <= '0;
      mem_addr_q   <= '0;
      core_rdata_q <= '0;
      core_rd_q    <= 1'b0;
      host_rd_q    <= 1'b0;
      rd_bad_q     <= 1'b0;
    end else begin
      clear_ptr_q  <= run ? clear_ptr_q : clear_ptr_q + DPW'(4);
      init_done_q  <= init_done_q | (state_q == CLEAR && state_d == RUN);
      wait_cnt_q   <= wait_cnt_d;
      mem_addr_q   <= mem_addr_o;
      core_rdata_q <= core_rdata_o;
      core_rd_q    <= core_grant & ~core_we_i;
      host_rd_q    <= host_grant & ~host_we_i;
      rd_bad_q     <= (core_grant & core_bad) | (host_grant & host_bad);
    end
  // outputs: grant mux to d_cache, handshakes, error pulses and read return
  always_comb begin
    host_ready_o  = host_grant;
    core_stall_o  = run ? core_req_i & ~core_grant : 1'b1;
    core_err_o    = core_grant & core_bad;
    host_err_o    = host_grant & host_bad;
    mem_we_o      = run ? (host_grant & host_we_i & ~host_bad) | (core_grant & core_we_i & ~core_bad) : ~rst;
    mem_addr_o    = !run ? clear_ptr_q : host_grant ? host_addr_i : core_grant ? core_addr_i : mem_addr_q;
    mem_wd_o      = !run ? '0 : host_grant ? host_wdata_i : core_grant ? core_wd_i : '0;
    core_rdata_o  = core_rd_q ? (rd_bad_q ? '0 : mem_rd_i) : core_rdata_q;
    host_rvalid_o = host_rd_q;
    host_rdata_o  = (host_rd_q & ~rd_bad_q) ? mem_rd_i : '0;
    init_done_o   = init_done_q;
  end
endmodule
